// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the IF stage: fetch FSM states plus the
// reset PC and bubble encoding.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// hold_i freezes everything; otherwise a load without flush captures the new
// word and any other cycle turns the register into a NOP bubble (pc kept).
module if_id_reg
  import cpu_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = cpu_pipe_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Next-state selection: hold, load, or bubble.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (!hold_i) begin
      if (load_i && !flush_i) begin
        instr_d = instr_i;
        pc_d    = pc_i;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end
  end

  // Register with asynchronous reset to the bubble state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_WORD;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF-stage fetch controller with single-outstanding imem requests, redirect
// handling and the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds saturating redirect/stall counters.
//
// state   | meaning
// S_ISSUE | drive imem_req for pc; late responses here are ignored
// S_WAIT  | request outstanding, waiting for imem_valid
// S_HOLD  | word arrived during stall, parked in the hold buffer
// S_DROP  | redirected while a request was in flight; swallow its response
module fetch_redirect_unit
  import cpu_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFFlush,
  input  logic        CHmux,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        valid_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         accept;
  logic [31:0]  accept_word;
  logic         redirect;
  logic         kill;
  logic [31:0]  pc_plus4;

  // A stalled ID stage re-evaluates its branch next cycle, so stall masks flush.
  assign redirect = IFFlush & CHmux & ~stall;
  assign kill     = IFFlush & ~stall;
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, next-PC and accept decision for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    accept      = 1'b0;
    accept_word = imem_rdata;
    unique case (state_q)
      S_ISSUE: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = imem_valid ? S_ISSUE : S_DROP;
        end else if (imem_valid) begin
          if (stall) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else begin
            // Flush without redirect still consumes the slot: pc moves on.
            accept  = ~kill;
            pc_d    = pc_plus4;
            state_d = S_ISSUE;
          end
        end
      end
      S_HOLD: begin
        accept_word = buf_q;
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_ISSUE;
        end else if (!stall) begin
          accept  = ~kill;
          pc_d    = pc_plus4;
          state_d = S_ISSUE;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (imem_valid) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // FSM state, PC and hold buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ISSUE;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Request is gated by reset so the port reads 0 while reset is held.
  assign imem_req  = (state_q == S_ISSUE) & ~reset;
  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk_i   (clk),
    .rst_i   (reset),
    .hold_i  (stall),
    .flush_i (kill),
    .load_i  (accept),
    .instr_i (accept_word),
    .pc_i    (pc_plus4),
    .instr_o (instr_id),
    .pc_o    (pc_id),
    .valid_o (valid_id)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating event counters for redirects and stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt_q <= 16'h0;
      stall_cnt_q    <= 16'h0;
    end else begin
      if (redirect && (redirect_cnt_q != 16'hFFFF)) redirect_cnt_q <= redirect_cnt_q + 16'd1;
      if (stall && (stall_cnt_q != 16'hFFFF))       stall_cnt_q    <= stall_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule
